// File: rtl/mfp_sonar_ranger.sv
// mfp_sonar_ranger: periodic HC-SR04 trigger plus echo timer reporting whole centimetres for IO_Sonar
module mfp_sonar_ranger #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TRIG_US    = 10,
    parameter int PERIOD_MS  = 60,
    parameter int TIMEOUT_US = 30000,
    parameter int CM_US      = 58
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        echo,
    output logic        trig,
    output logic [15:0] distance,
    output logic        valid,
    output logic        timeout,
    output logic        busy
);
    localparam int          US_CYC      = CLK_HZ / 1_000_000;
    localparam logic [31:0] TRIG_CYC    = TRIG_US * US_CYC;
    localparam logic [31:0] PERIOD_CYC  = PERIOD_MS * 1000 * US_CYC;
    localparam logic [31:0] TIMEOUT_CYC = TIMEOUT_US * US_CYC;
    localparam logic [31:0] CM_CYC      = CM_US * US_CYC;

    typedef enum logic [1:0] {IDLE, TRIG, WAIT_RISE, MEASURE} state_t;

    state_t      r_state, w_next;
    logic        r_echo_m, r_echo_s, r_echo_d;
    logic [31:0] r_period, r_timer, r_sub;
    logic [15:0] r_cm, w_cm_inc;
    logic        w_rise, w_fall, w_tout, w_done, w_res;

    always_comb begin
        w_rise   = r_echo_s & ~r_echo_d;
        w_fall   = ~r_echo_s & r_echo_d;
        w_tout   = r_timer == TIMEOUT_CYC - 1;
        w_cm_inc = (r_sub == CM_CYC - 1 && r_cm != 16'hFFFE) ? r_cm + 16'd1 : r_cm;
        w_next   = r_state;
        case (r_state)
            IDLE:      w_next = (enable && r_period == '0) ? TRIG : IDLE;
            TRIG:      w_next = (r_timer == TRIG_CYC - 1) ? WAIT_RISE : TRIG;
            WAIT_RISE: w_next = w_rise ? MEASURE : (w_tout ? IDLE : WAIT_RISE);
            MEASURE:   w_next = (w_fall || w_tout) ? IDLE : MEASURE;
            default:   w_next = IDLE;
        endcase
        w_done = r_state == MEASURE && w_fall;
        w_res  = (r_state == WAIT_RISE || r_state == MEASURE) && w_next == IDLE;
    end

    assign busy = r_state != IDLE;

    // distance takes the count including the final cycle, so it equals floor(width/CM_CYC)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_echo_m <= 1'b0;
            r_echo_s <= 1'b0;
            r_echo_d <= 1'b0;
            r_period <= '0;
            r_timer  <= '0;
            r_sub    <= '0;
            r_cm     <= '0;
            trig     <= 1'b0;
            distance <= '0;
            valid    <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_echo_m <= echo;
            r_echo_s <= r_echo_m;
            r_echo_d <= r_echo_s;
            trig     <= w_next == TRIG;
            r_period <= (r_state == IDLE && w_next == TRIG) ? PERIOD_CYC - 1 :
                        (r_period != '0) ? r_period - 1 : '0;
            r_timer  <= (w_next != r_state || r_state == IDLE) ? '0 : r_timer + 1;
            r_sub    <= (r_state != MEASURE) ? '0 : (r_sub == CM_CYC - 1) ? '0 : r_sub + 1;
            r_cm     <= (r_state != MEASURE) ? '0 : w_cm_inc;
            valid    <= w_res;
            distance <= w_res ? (w_done ? w_cm_inc : 16'hFFFF) : distance;
            timeout  <= w_res ? ~w_done : timeout;
        end
    end
endmodule
